alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the integer ALU for a single issued instruction.
- Accepts a decoded op from issue via a valid/ready handshake, then reads operands over the register file's single read port.
- Launches the ALU, waits for completion, and writes the result back through the register file write port, or into HI/LO for mult/div.
- Sits between the decode/issue stage, register_file and int_alu.

Parameters:
DW, 32, datapath width (operands, result, HI/LO)
RW, 5, register select width
TIMEOUT_CYCLES, 64, WAIT watchdog limit (used only with ALU_TIMEOUT_EN)

Ports:
c  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
issue_valid  in  1  instruction offered
issue_ready  out  1  sequencer can accept
issue_funct  in  6  ALU op code (ALU encoding, e.g. 100000 add)
issue_rs / issue_rt / issue_rd  in  RW each  source A / source B / destination
issue_imm  in  16  immediate
issue_shamt  in  5  shift amount
issue_use_imm  in  1  B operand = extended immediate/shamt instead of rt
rf_rsel  out  RW  register file read select
rf_rdata  in  DW  read data, valid cycle after rf_rsel
rf_wsel  out  RW  write select
rf_wen  out  1  write enable (one-cycle pulse)
rf_wdata  out  DW  write data
alu_op  out  6  op to ALU
alu_a / alu_b  out  DW each  operands
alu_start  out  1  one-cycle launch pulse
alu_done  in  1  result valid
alu_result  in  DW  result (LO for mult/div)
alu_result_hi  in  DW  HI for mult/div
hi / lo  out  DW each  HI/LO registers
busy  out  1  state != IDLE
err_illegal  out  1  one-cycle pulse: unsupported funct accepted
err_timeout  out  1  one-cycle pulse: watchdog fired

Behaviour:
- Clock is c; reset is synchronous, active-high.
- Reset values: state IDLE, issue_ready 1, rf_wen 0, alu_start 0, hi/lo 0, err pulses 0, all captured operand/op registers 0.
- A reset mid-operation drops the op with no writeback.
- States: IDLE -> RD_RS -> RD_RT -> EXEC -> WAIT -> WB -> IDLE.
- IDLE:
  - issue_ready=1 only here.
  - Handshake = issue_valid & issue_ready; latches funct, rs, rt, rd, imm, shamt, use_imm.
  - Unsupported funct: stay IDLE, err_illegal pulses the next cycle.
- RD_RS: rf_rsel=rs.
- RD_RT: rf_rsel=rt; opa <= (rs==0) ? 0 : rf_rdata.
- Immediate ops still pass through RD_RT; the sequence is uniform.
- EXEC:
  - alu_start=1.
  - alu_b driven from the operand mux this cycle:
    - use_imm and funct in {addi, addiu}: sign-extended imm.
    - {andi, ori, xori}: zero-extended imm.
    - {sll, sra, srl}: zero-extended shamt.
    - Otherwise: (rt==0) ? 0 : rf_rdata.
  - Mux value captured into opb; alu_b = opb afterwards.
  - alu_a = opa from EXEC on; alu_op = latched funct.
- WAIT: alu_done is sampled only here, first at the cycle after EXEC. On alu_done, capture result(s) and go to WB.
- WB:
  - mult/multu/div/divu: hi <= alu_result_hi, lo <= alu_result, rf_wen=0.
  - Otherwise: rf_wen=1, rf_wsel=rd, rf_wdata=result. rd==0 suppresses rf_wen.
- Latency: handshake edge to rf_wen is 5 cycles when alu_done is asserted in the first WAIT cycle.
- Back-to-back issue: next accept in the cycle after WB.
- issue_valid while busy is ignored; the offer must be held.
- No writeback forwarding is needed: one op in flight.

Optional Feature:
- ALU_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without alu_done: go to IDLE, no writeback, hi/lo unchanged, err_timeout pulses one cycle.
  - alu_done in the same cycle as expiry wins (normal WB).
- Undefined: WAIT waits indefinitely; err_timeout tied 0; no counter logic.

Decomposition:
- Shared package alu_seq_pkg holds:
  - funct constants FN_ADD, FN_ADDU, FN_ADDI, FN_ADDIU, FN_AND, FN_ANDI, FN_DIV, FN_DIVU, FN_MULT, FN_MULTU, FN_NOR, FN_OR, FN_ORI, FN_SLL, FN_SLLV, FN_SRA, FN_SRAV, FN_SRL, FN_SRLV, FN_SUB, FN_SUBU, FN_XOR, FN_XORI.
  - State encoding.
  - Helper functions is_supported, is_hilo, ext_kind.
- One sub-module, alu_operand_ext: combinational B-operand selection and extension.

Test Plan:
- Reg image r3=5, r4=7; add rs=3 rt=4 rd=2; ALU done 1 cycle after start -> rf_wen once, wsel=2, wdata=12, exactly 5 cycles after handshake.
- addi rs=3 imm=16'hFFFF -> alu_b=32'hFFFFFFFF; ori same imm -> alu_b=32'h0000FFFF; sll shamt=4 -> alu_b=4.
- mult r3=5 r4=7, alu_result_hi=0, alu_result=35 -> lo=35, hi=0, rf_wen never asserted; add rd=0 -> no rf_wen; rs=0 with rf_rdata=32'hDEAD -> alu_a=0.
- funct=6'b111111 offered -> err_illegal pulse, busy stays 0, rf_wen/alu_start never asserted.
- rst asserted during WAIT -> next cycle IDLE, issue_ready=1, no rf_wen, hi/lo=0; issue_valid held while busy -> accepted only after WB.
- ALU_TIMEOUT_EN, alu_done held 0 -> err_timeout after 64 WAIT cycles, no writeback; alu_done at cycle 64 -> normal writeback.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared funct codes, FSM state encoding and operand-selection helpers for alu_sequencer.
package alu_seq_pkg;

   localparam int unsigned FW   = 6;
   localparam int unsigned IMMW = 16;
   localparam int unsigned SHW  = 5;

   localparam logic [FW-1:0] FN_SLL   = 6'b000000;
   localparam logic [FW-1:0] FN_SRL   = 6'b000010;
   localparam logic [FW-1:0] FN_SRA   = 6'b000011;
   localparam logic [FW-1:0] FN_SLLV  = 6'b000100;
   localparam logic [FW-1:0] FN_SRLV  = 6'b000110;
   localparam logic [FW-1:0] FN_SRAV  = 6'b000111;
   localparam logic [FW-1:0] FN_ADDI  = 6'b001000;
   localparam logic [FW-1:0] FN_ADDIU = 6'b001001;
   localparam logic [FW-1:0] FN_ANDI  = 6'b001100;
   localparam logic [FW-1:0] FN_ORI   = 6'b001101;
   localparam logic [FW-1:0] FN_XORI  = 6'b001110;
   localparam logic [FW-1:0] FN_MULT  = 6'b011000;
   localparam logic [FW-1:0] FN_MULTU = 6'b011001;
   localparam logic [FW-1:0] FN_DIV   = 6'b011010;
   localparam logic [FW-1:0] FN_DIVU  = 6'b011011;
   localparam logic [FW-1:0] FN_ADD   = 6'b100000;
   localparam logic [FW-1:0] FN_ADDU  = 6'b100001;
   localparam logic [FW-1:0] FN_SUB   = 6'b100010;
   localparam logic [FW-1:0] FN_SUBU  = 6'b100011;
   localparam logic [FW-1:0] FN_AND   = 6'b100100;
   localparam logic [FW-1:0] FN_OR    = 6'b100101;
   localparam logic [FW-1:0] FN_XOR   = 6'b100110;
   localparam logic [FW-1:0] FN_NOR   = 6'b100111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_RS = 3'd1,
      ST_RD_RT = 3'd2,
      ST_EXEC  = 3'd3,
      ST_WAIT  = 3'd4,
      ST_WB    = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      EXT_REG   = 2'd0,
      EXT_SIMM  = 2'd1,
      EXT_ZIMM  = 2'd2,
      EXT_SHAMT = 2'd3
   } ext_kind_t;

   // Decoded op fields held for the duration of one instruction
   typedef struct packed {
      logic [FW-1:0]   funct;
      logic [IMMW-1:0] imm;
      logic [SHW-1:0]  shamt;
      logic            use_imm;
   } op_t;

   function automatic logic is_supported(input logic [FW-1:0] f);
      case (f)
         FN_ADD, FN_ADDU, FN_ADDI, FN_ADDIU, FN_AND, FN_ANDI, FN_DIV, FN_DIVU,
         FN_MULT, FN_MULTU, FN_NOR, FN_OR, FN_ORI, FN_SLL, FN_SLLV, FN_SRA,
         FN_SRAV, FN_SRL, FN_SRLV, FN_SUB, FN_SUBU, FN_XOR, FN_XORI: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_hilo(input logic [FW-1:0] f);
      return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
   endfunction

   function automatic ext_kind_t ext_kind(input logic [FW-1:0] f, input logic use_imm);
      if (!use_imm)                                       return EXT_REG;
      if ((f == FN_ADDI) || (f == FN_ADDIU))              return EXT_SIMM;
      if ((f == FN_ANDI) || (f == FN_ORI) || (f == FN_XORI)) return EXT_ZIMM;
      if ((f == FN_SLL) || (f == FN_SRA) || (f == FN_SRL))   return EXT_SHAMT;
      return EXT_REG;
   endfunction

endpackage

// File: rtl/alu_operand_ext.sv
// Combinational B-operand select: register value, sign/zero-extended immediate, or shift amount.
module alu_operand_ext
   import alu_seq_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  ext_kind_t       kind,
   input  logic [IMMW-1:0] imm,
   input  logic [SHW-1:0]  shamt,
   input  logic            rt_zero,
   input  logic [DW-1:0]   rdata,
   output logic [DW-1:0]   operand_c
);

   always_comb begin
      operand_c = '0;
      case (kind)
         EXT_SIMM:  operand_c = DW'($signed(imm));
         EXT_ZIMM:  operand_c = DW'(imm);
         EXT_SHAMT: operand_c = DW'(shamt);
         EXT_REG:   operand_c = rt_zero ? '0 : rdata;
         default:   operand_c = '0;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: issue handshake, two RF reads, ALU launch/wait, writeback or HI/LO update.
// Optional WAIT watchdog enabled by defining ALU_TIMEOUT_EN.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned DW             = 32,
   parameter int unsigned RW             = 5,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic            c,
   input  logic            rst,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [FW-1:0]   issue_funct,
   input  logic [RW-1:0]   issue_rs,
   input  logic [RW-1:0]   issue_rt,
   input  logic [RW-1:0]   issue_rd,
   input  logic [IMMW-1:0] issue_imm,
   input  logic [SHW-1:0]  issue_shamt,
   input  logic            issue_use_imm,
   output logic [RW-1:0]   rf_rsel,
   input  logic [DW-1:0]   rf_rdata,
   output logic [RW-1:0]   rf_wsel,
   output logic            rf_wen,
   output logic [DW-1:0]   rf_wdata,
   output logic [FW-1:0]   alu_op,
   output logic [DW-1:0]   alu_a,
   output logic [DW-1:0]   alu_b,
   output logic            alu_start,
   input  logic            alu_done,
   input  logic [DW-1:0]   alu_result,
   input  logic [DW-1:0]   alu_result_hi,
   output logic [DW-1:0]   hi,
   output logic [DW-1:0]   lo,
   output logic            busy,
   output logic            err_illegal,
   output logic            err_timeout
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be nonzero");
   end

   state_t        state, state_nxt;
   op_t           op_q;
   logic [RW-1:0] rs_q, rt_q, rd_q;
   logic [DW-1:0] opa, opb, res_lo, res_hi, b_mux;
   logic          wd_expire;

   alu_operand_ext #(.DW(DW)) u_ext (
      .kind      (ext_kind(op_q.funct, op_q.use_imm)),
      .imm       (op_q.imm),
      .shamt     (op_q.shamt),
      .rt_zero   (rt_q == '0),
      .rdata     (rf_rdata),
      .operand_c (b_mux)
   );

   always_ff @(posedge c) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (issue_valid && is_supported(issue_funct)) state_nxt = ST_RD_RS;
         ST_RD_RS: state_nxt = ST_RD_RT;
         ST_RD_RT: state_nxt = ST_EXEC;
         ST_EXEC:  state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (alu_done)       state_nxt = ST_WB;
            else if (wd_expire) state_nxt = ST_IDLE;
         end
         ST_WB:    state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      issue_ready = (state == ST_IDLE);
      busy        = (state != ST_IDLE);
      rf_rsel     = (state == ST_RD_RT) ? rt_q : rs_q;
      alu_start   = (state == ST_EXEC);
      alu_op      = op_q.funct;
      alu_a       = opa;
      alu_b       = (state == ST_EXEC) ? b_mux : opb;
      rf_wsel     = rd_q;
      rf_wdata    = res_lo;
      rf_wen      = (state == ST_WB) && !is_hilo(op_q.funct) && (rd_q != '0);
   end

   // Operand, result and HI/LO capture along the sequence
   always_ff @(posedge c) begin
      if (rst) begin
         op_q        <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         opa         <= '0;
         opb         <= '0;
         res_lo      <= '0;
         res_hi      <= '0;
         hi          <= '0;
         lo          <= '0;
         err_illegal <= 1'b0;
      end else begin
         err_illegal <= 1'b0;
         if (state == ST_IDLE && issue_valid) begin
            op_q        <= '{funct: issue_funct, imm: issue_imm, shamt: issue_shamt,
                             use_imm: issue_use_imm};
            rs_q        <= issue_rs;
            rt_q        <= issue_rt;
            rd_q        <= issue_rd;
            err_illegal <= !is_supported(issue_funct);
         end
         if (state == ST_RD_RT) opa <= (rs_q == '0) ? '0 : rf_rdata;
         if (state == ST_EXEC)  opb <= b_mux;
         if (state == ST_WAIT && alu_done) begin
            res_lo <= alu_result;
            res_hi <= alu_result_hi;
         end
         if (state == ST_WB && is_hilo(op_q.funct)) begin
            hi <= res_hi;
            lo <= res_lo;
         end
      end
   end

`ifdef ALU_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wd_cnt;

   assign wd_expire = (state == ST_WAIT) && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Counts WAIT cycles; held at zero elsewhere so each WAIT entry starts fresh
   always_ff @(posedge c) begin
      if (rst) begin
         wd_cnt      <= '0;
         err_timeout <= 1'b0;
      end else begin
         err_timeout <= wd_expire && !alu_done;
         wd_cnt      <= (state == ST_WAIT) ? wd_cnt + CW'(1) : '0;
      end
   end
`else
   assign wd_expire   = 1'b0;
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer with RF/ALU stubs; define ALU_TIMEOUT_EN for watchdog cases.
`timescale 1ns/1ps
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   logic        c = 1'b0;
   logic        rst;
   logic        issue_valid, issue_ready, issue_use_imm;
   logic [5:0]  issue_funct, alu_op;
   logic [4:0]  issue_rs, issue_rt, issue_rd, issue_shamt, rf_rsel, rf_wsel;
   logic [15:0] issue_imm;
   logic [31:0] rf_rdata, rf_wdata, alu_a, alu_b, alu_result, alu_result_hi, hi, lo;
   logic        rf_wen, alu_start, alu_done, busy, err_illegal, err_timeout;

   always #5 c = ~c;

   alu_sequencer dut (
      .c(c), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_funct(issue_funct), .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
      .issue_imm(issue_imm), .issue_shamt(issue_shamt), .issue_use_imm(issue_use_imm),
      .rf_rsel(rf_rsel), .rf_rdata(rf_rdata), .rf_wsel(rf_wsel), .rf_wen(rf_wen),
      .rf_wdata(rf_wdata), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
      .alu_result_hi(alu_result_hi), .hi(hi), .lo(lo), .busy(busy),
      .err_illegal(err_illegal), .err_timeout(err_timeout)
   );

   // kind: 0 normal op, 1 illegal funct, 2 watchdog expiry
   typedef struct {
      int          kind;
      logic [31:0] a, b, wdata, hi, lo;
      bit          wen;
      logic [4:0]  wsel;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          dly_q[$];
   int          vectors = 0, miscompares = 0;
   logic [31:0] rf[32], mregs[32];
   logic [31:0] mhi, mlo;
   logic [5:0]  fn_list[23];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Behavioural ALU: returns {hi, lo}
   function automatic logic [63:0] alu_ref(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb2;
      sa = $signed(a);
      sb2 = $signed(b);
      case (f)
         FN_ADD, FN_ADDU, FN_ADDI, FN_ADDIU: return {32'h0, a + b};
         FN_SUB, FN_SUBU:  return {32'h0, a - b};
         FN_AND, FN_ANDI:  return {32'h0, a & b};
         FN_OR,  FN_ORI:   return {32'h0, a | b};
         FN_XOR, FN_XORI:  return {32'h0, a ^ b};
         FN_NOR:           return {32'h0, ~(a | b)};
         FN_SLL, FN_SLLV:  return {32'h0, a << b[4:0]};
         FN_SRL, FN_SRLV:  return {32'h0, a >> b[4:0]};
         FN_SRA, FN_SRAV:  return {32'h0, 32'($signed(a) >>> b[4:0])};
         FN_MULT:          return 64'(sa * sb2);
         FN_MULTU:         return {32'h0, a} * {32'h0, b};
         FN_DIV: begin
            if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 64'h0;
            return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
         end
         FN_DIVU: begin
            if (b == 0) return 64'h0;
            return {a % b, a / b};
         end
         default: return 64'h0;
      endcase
   endfunction

   function automatic bit listed(input logic [5:0] f);
      foreach (fn_list[i]) if (fn_list[i] == f) return 1'b1;
      return 1'b0;
   endfunction

   // Register file stub: read data one cycle after select
   always @(posedge c) begin
      rf_rdata <= rf[rf_rsel];
      if (rf_wen) rf[rf_wsel] <= rf_wdata;
   end

   // ALU stub: per-op delay taken from dly_q; negative delay never completes
   int alu_cnt;
   bit alu_pend;
   always @(posedge c) begin
      int d;
      if (rst) begin
         dly_q.delete();
         alu_done <= 1'b0;
         alu_pend <= 1'b0;
      end else begin
         alu_done <= 1'b0;
         if (alu_start) begin
            d = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
            {alu_result_hi, alu_result} <= alu_ref(alu_op, alu_a, alu_b);
            if (d == 0) alu_done <= 1'b1;
            else if (d > 0) begin
               alu_pend <= 1'b1;
               alu_cnt  <= d - 1;
            end
         end else if (alu_pend) begin
            if (alu_cnt == 0) begin
               alu_done <= 1'b1;
               alu_pend <= 1'b0;
            end else alu_cnt <= alu_cnt - 1;
         end
      end
   end

   // Monitor: pops expectations on err_illegal or when busy drops
   int          cyc = 0, hs_cyc = 0, wen_cyc = 0, to_cyc = 0, fall_cyc = 0;
   int          wen_cnt = 0, start_cnt = 0, to_cnt = 0;
   logic [31:0] cap_a, cap_b, cap_wdata;
   logic [4:0]  cap_wsel;
   bit          prev_busy = 0, held = 0;
   always @(negedge c) begin
      exp_t e;
      cyc++;
      if (rst) begin
         sb.delete();
         prev_busy = 0; held = 0; wen_cnt = 0; start_cnt = 0; to_cnt = 0;
      end else begin
         if (alu_start) begin start_cnt++; cap_a = alu_a; cap_b = alu_b; end
         if (rf_wen) begin wen_cnt++; cap_wsel = rf_wsel; cap_wdata = rf_wdata; wen_cyc = cyc; end
         if (err_timeout) begin to_cnt++; to_cyc = cyc; end
         if (err_illegal) begin
            if (sb.size() == 0) flag("unexpected_err_illegal");
            else begin
               e = sb.pop_front();
               chk("illegal_kind", 32'(e.kind), 32'd1);
               chk("illegal_busy", 32'(busy), 32'd0);
               chk("illegal_alu_start", 32'(start_cnt), 32'd0);
               chk("illegal_rf_wen", 32'(wen_cnt), 32'd0);
            end
         end
         if (prev_busy && !busy) begin
            fall_cyc = cyc;
            if (sb.size() == 0) flag("unexpected_completion");
            else begin
               e = sb.pop_front();
               chk("op_kind_not_illegal", 32'(e.kind == 1), 32'd0);
               chk("alu_start_pulses", 32'(start_cnt), 32'd1);
               chk("alu_a", cap_a, e.a);
               chk("alu_b", cap_b, e.b);
               chk("rf_wen_pulses", 32'(wen_cnt), 32'(e.wen));
               if (e.wen && wen_cnt == 1) begin
                  chk("rf_wsel", 32'(cap_wsel), 32'(e.wsel));
                  chk("rf_wdata", cap_wdata, e.wdata);
                  chk("wb_latency", 32'(wen_cyc - hs_cyc), 32'(e.lat));
               end
               chk("hi", hi, e.hi);
               chk("lo", lo, e.lo);
               chk("err_timeout_pulses", 32'(to_cnt), 32'(e.kind == 2));
               if (e.kind == 2 && to_cnt == 1) chk("timeout_latency", 32'(to_cyc - hs_cyc), 32'd68);
            end
         end
         if (issue_valid && busy) held = 1;
         if (issue_valid && issue_ready) begin
            if (held) chk("accept_after_wb", 32'(cyc), 32'(fall_cyc));
            held = 0; hs_cyc = cyc; wen_cnt = 0; start_cnt = 0; to_cnt = 0;
         end
         prev_busy = busy;
      end
   end

   // Compute expectation from architectural rules, then offer and hold until accepted
   task automatic issue(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [4:0] sh,
                        input bit ui, input int dly);
      exp_t e;
      logic [63:0] r;
      logic [31:0] rtv;
      int n;
      e.kind = !listed(f) ? 1 : (dly < 0) ? 2 : 0;
      e.a = 0; e.b = 0; e.wen = 0; e.wsel = rd; e.wdata = 0; e.lat = 5 + dly;
      if (e.kind != 1) begin
         e.a = (rs == 0) ? 32'h0 : mregs[rs];
         rtv = (rt == 0) ? 32'h0 : mregs[rt];
         if (ui && (f == FN_ADDI || f == FN_ADDIU))             e.b = {{16{imm[15]}}, imm};
         else if (ui && (f inside {FN_ANDI, FN_ORI, FN_XORI}))  e.b = {16'h0, imm};
         else if (ui && (f inside {FN_SLL, FN_SRA, FN_SRL}))    e.b = {27'h0, sh};
         else                                                   e.b = rtv;
         dly_q.push_back(dly);
         if (e.kind == 0) begin
            r = alu_ref(f, e.a, e.b);
            if (f inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU}) begin
               mhi = r[63:32]; mlo = r[31:0];
            end else if (rd != 0) begin
               e.wen = 1; e.wdata = r[31:0]; mregs[rd] = r[31:0];
            end
         end
      end
      e.hi = mhi; e.lo = mlo;
      sb.push_back(e);
      issue_funct = f; issue_rs = rs; issue_rt = rt; issue_rd = rd;
      issue_imm = imm; issue_shamt = sh; issue_use_imm = ui; issue_valid = 1'b1;
      n = 0;
      do begin @(negedge c); n++; end while (!issue_ready && n < 400);
      if (!issue_ready) flag("handshake_timeout");
      @(posedge c); #1;
      issue_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 500) begin @(negedge c); n++; end
      chk("drain_queue_empty", 32'(sb.size()), 32'd0);
      @(posedge c); #1;
   endtask

   initial begin
      int n;
      logic [5:0] f;
      fn_list = '{FN_ADD, FN_ADDU, FN_ADDI, FN_ADDIU, FN_AND, FN_ANDI, FN_DIV, FN_DIVU,
                  FN_MULT, FN_MULTU, FN_NOR, FN_OR, FN_ORI, FN_SLL, FN_SLLV, FN_SRA,
                  FN_SRAV, FN_SRL, FN_SRLV, FN_SUB, FN_SUBU, FN_XOR, FN_XORI};
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0] = 32'hDEAD; rf[3] = 5; rf[4] = 7;
      for (int i = 0; i < 32; i++) mregs[i] = rf[i];
      mhi = 0; mlo = 0; rf_rdata = 0;
      rst = 1'b1; issue_valid = 1'b0; issue_funct = 0; issue_rs = 0; issue_rt = 0;
      issue_rd = 0; issue_imm = 0; issue_shamt = 0; issue_use_imm = 0;
      repeat (3) @(posedge c);
      #1 rst = 1'b0;
      @(negedge c);
      chk("reset_issue_ready", 32'(issue_ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rf_wen", 32'(rf_wen), 32'd0);
      chk("reset_alu_start", 32'(alu_start), 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_err_illegal", 32'(err_illegal), 32'd0);
      chk("reset_err_timeout", 32'(err_timeout), 32'd0);
      @(posedge c); #1;

      issue(FN_ADD,   3, 4, 2, 16'h0,    5'd0, 1'b0, 0);
      issue(FN_ADDI,  3, 0, 7, 16'hFFFF, 5'd0, 1'b1, 1);
      issue(FN_ORI,   3, 0, 8, 16'hFFFF, 5'd0, 1'b1, 0);
      issue(FN_SLL,   3, 0, 9, 16'h0,    5'd4, 1'b1, 2);
      issue(FN_MULT,  3, 4, 10, 16'h0,   5'd0, 1'b0, 0);
      issue(FN_ADD,   3, 4, 0, 16'h0,    5'd0, 1'b0, 0);
      issue(FN_ADD,   0, 4, 11, 16'h0,   5'd0, 1'b0, 0);
      issue(6'b111111, 3, 4, 12, 16'h0,  5'd0, 1'b0, 0);
      issue(FN_ADDU,  3, 4, 13, 16'h0,   5'd0, 1'b0, 3);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 19) == 0) f = 6'b111111;
         else f = fn_list[$urandom_range(0, 22)];
         issue(f, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), 16'($urandom), 5'($urandom),
               1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
      wait_drain();

      // Reset while the ALU is outstanding drops the op
      issue(FN_MULT, 3, 4, 0, 16'h0, 5'd0, 1'b0, 1000);
      n = 0;
      while (!alu_start && n < 20) begin @(negedge c); n++; end
      if (!alu_start) flag("reset_test_no_alu_start");
      repeat (2) @(negedge c);
      @(posedge c); #1;
      rst = 1'b1; mhi = 0; mlo = 0;
      @(posedge c);
      @(negedge c);
      chk("midop_reset_issue_ready", 32'(issue_ready), 32'd1);
      chk("midop_reset_busy", 32'(busy), 32'd0);
      chk("midop_reset_rf_wen", 32'(rf_wen), 32'd0);
      chk("midop_reset_hi", hi, 32'd0);
      chk("midop_reset_lo", lo, 32'd0);
      @(posedge c); #1;
      rst = 1'b0;
      issue(FN_SUB, 4, 3, 14, 16'h0, 5'd0, 1'b0, 0);

`ifdef ALU_TIMEOUT_EN
      issue(FN_ADD, 3, 4, 15, 16'h0, 5'd0, 1'b0, -1);
      issue(FN_ADD, 3, 4, 16, 16'h0, 5'd0, 1'b0, 63);
`endif
      wait_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
